// File: rtl/uart_mcu_host.sv
// uart_mcu_host: one-at-a-time command initiator that sends opcode/data bytes to a UART byte transmitter and collects read responses
// Ports:
//   sys_clk, sys_rst_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid, cmd_ready          command handshake, accepted on cmd_valid & cmd_ready
//   cmd_op, cmd_data              opcode and write data byte
//   rsp_valid, rsp_data, rsp_last one pulse per response byte; rsp_last marks the final one
//   done, err                     completion pulse; err=1 marks a response timeout
//   uart_send, uart_data_w        transmit strobe and byte to the byte transmitter
//   uart_rec, uart_data_r         receive-complete level and received byte from the byte receiver
module uart_mcu_host #(
  parameter int BYTE_GAP    = 3000,
  parameter int RSP_TIMEOUT = 1000000,
  parameter int BURST_LEN   = 512
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       done,
  output logic       err,
  output logic       uart_send,
  output logic [7:0] uart_data_w,
  input  logic       uart_rec,
  input  logic [7:0] uart_data_r
);
  localparam int GW = $clog2(BYTE_GAP + 1);
  localparam int TW = $clog2(RSP_TIMEOUT + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_SEND_OP, S_GAP_OP, S_SEND_DATA, S_GAP_DATA, S_WAIT_RSP, S_FINISH
  } state_t;
  typedef enum logic [1:0] {C_NONE, C_WR1, C_RD1, C_RDB} cls_t;
  state_t        state, state_n;
  cls_t          cls;
  logic [7:0]    data;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] byte_cnt;
  logic          uart_rec_last, rx, accept, in_gap, gap_end, tmo_end, last_byte, take, timeout;
  function automatic cls_t decode(input logic [7:0] op);
    return (op[7:3] == 5'h06 || op[7:3] == 5'h08) ? C_WR1 :
           (op[7:3] == 5'h04 || op[7:3] == 5'h0A) ? C_RD1 :
           (op == 8'hA3)                          ? C_RDB : C_NONE;
  endfunction
  assign rx        = uart_rec & ~uart_rec_last;
  assign accept    = (state == S_IDLE) & cmd_valid;
  assign in_gap    = (state == S_GAP_OP) || (state == S_GAP_DATA);
  assign gap_end   = gap_cnt == GW'(BYTE_GAP - 1);
  assign tmo_end   = tmo_cnt == TW'(RSP_TIMEOUT - 1);
  assign last_byte = byte_cnt == ((cls == C_RDB) ? BW'(BURST_LEN - 1) : BW'(0));
  assign take      = (state == S_WAIT_RSP) & rx;
  // a byte arriving on the timeout compare cycle wins over the timeout
  assign timeout   = (state == S_WAIT_RSP) & ~rx & tmo_end;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    uart_send = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        // held low while reset is asserted so every output reads 0 in reset
        cmd_ready = sys_rst_n;
        state_n   = cmd_valid ? S_SEND_OP : S_IDLE;
      end
      S_SEND_OP: begin
        uart_send = 1'b1;
        state_n   = S_GAP_OP;
      end
      S_GAP_OP:
        state_n = !gap_end ? S_GAP_OP :
                  (cls == C_WR1) ? S_SEND_DATA :
                  (cls == C_NONE) ? S_FINISH : S_WAIT_RSP;
      S_SEND_DATA: begin
        uart_send = 1'b1;
        state_n   = S_GAP_DATA;
      end
      S_GAP_DATA: state_n = gap_end ? S_FINISH : S_GAP_DATA;
      S_WAIT_RSP: state_n = ((take & last_byte) | timeout) ? S_FINISH : S_WAIT_RSP;
      S_FINISH: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      uart_rec_last <= 1'b0;
      cls           <= C_NONE;
      data          <= 8'h00;
      gap_cnt       <= '0;
      tmo_cnt       <= '0;
      byte_cnt      <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= 8'h00;
      rsp_last      <= 1'b0;
      err           <= 1'b0;
      uart_data_w   <= 8'h00;
    end else begin
      uart_rec_last <= uart_rec;
      rsp_valid     <= take;
      rsp_last      <= take & last_byte;
      gap_cnt       <= (in_gap && !gap_end) ? gap_cnt + 1'b1 : '0;
      // zero outside WAIT_RSP, so the count restarts on entry and after every byte
      tmo_cnt       <= (state == S_WAIT_RSP && !rx && !tmo_end) ? tmo_cnt + 1'b1 : '0;
      if (accept) begin
        cls         <= decode(cmd_op);
        data        <= cmd_data;
        uart_data_w <= cmd_op;
        byte_cnt    <= '0;
        err         <= 1'b0;
      end
      if (state == S_GAP_OP && gap_end && cls == C_WR1) uart_data_w <= data;
      if (take) begin
        rsp_data <= uart_data_r;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (timeout) err <= 1'b1;
    end
endmodule

// File: tb/tb_uart_mcu_host.sv
// tb_uart_mcu_host: directed self-checking bench for uart_mcu_host with short gap/timeout/burst parameters
module tb_uart_mcu_host;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_op = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_last, done, err, uart_send;
  logic [7:0] rsp_data, uart_data_w;
  logic       uart_rec = 1'b0;
  logic [7:0] uart_data_r = 8'h00;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         t;
  int         send_cyc[$];
  logic [7:0] send_b[$];
  int         rsp_cyc[$];
  logic [7:0] rsp_b[$];
  logic       rsp_l[$];
  int         done_cyc[$];
  logic       done_e[$];
  uart_mcu_host #(.BYTE_GAP(4), .RSP_TIMEOUT(20), .BURST_LEN(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .done(done), .err(err), .uart_send(uart_send),
    .uart_data_w(uart_data_w), .uart_rec(uart_rec), .uart_data_r(uart_data_r)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    if (uart_send) begin
      send_cyc.push_back(cyc);
      send_b.push_back(uart_data_w);
    end
    if (rsp_valid) begin
      rsp_cyc.push_back(cyc);
      rsp_b.push_back(rsp_data);
      rsp_l.push_back(rsp_last);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_e.push_back(err);
    end
  endtask
  task automatic clr();
    send_cyc.delete();
    send_b.delete();
    rsp_cyc.delete();
    rsp_b.delete();
    rsp_l.delete();
    done_cyc.delete();
    done_e.delete();
  endtask
  task automatic issue(input logic [7:0] op, input logic [7:0] d, output int tt);
    clr();
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tt        = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input int max);
    for (int i = 0; i < max && done_cyc.size() == 0; i++) tick();
    check("done_seen", done_cyc.size(), 1);
  endtask
  task automatic rx_byte(input logic [7:0] b);
    uart_rec    = 1'b1;
    uart_data_r = b;
    tick();
    uart_rec = 1'b0;
  endtask
  function automatic int dc0();
    return done_cyc.size() > 0 ? done_cyc[0] : -1;
  endfunction
  function automatic logic de0();
    return done_e.size() > 0 ? done_e[0] : 1'bx;
  endfunction
  initial begin
    // reset state
    repeat (3) tick();
    check("reset_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_last, done, err, uart_send, uart_data_w}, 0);
    sys_rst_n = 1'b1;
    #1;
    check("ready_after_reset", cmd_ready, 1);
    tick();
    // WR1 0x31 / 0x5A
    issue(8'h31, 8'h5A, t);
    wait_done(40);
    check("wr1_send_count", send_b.size(), 2);
    check("wr1_op_cycle", send_cyc.size() > 0 ? send_cyc[0] - t : -1, 1);
    check("wr1_op_byte", send_b.size() > 0 ? send_b[0] : 8'hxx, 8'h31);
    check("wr1_data_cycle", send_cyc.size() > 1 ? send_cyc[1] - t : -1, 6);
    check("wr1_data_byte", send_b.size() > 1 ? send_b[1] : 8'hxx, 8'h5A);
    check("wr1_done_cycle", dc0() - t, 11);
    check("wr1_err", de0(), 0);
    check("wr1_ready_at_done", cmd_ready, 0);
    tick();
    check("wr1_ready_after_done", cmd_ready, 1);
    check("wr1_no_rsp", rsp_b.size(), 0);
    // RD1 0x52, reply 0xC3 five cycles after WAIT_RSP entry (T+6)
    issue(8'h52, 8'h00, t);
    while (cyc < t + 11) tick();
    rx_byte(8'hC3);
    wait_done(40);
    repeat (3) tick();
    check("rd1_rsp_count", rsp_b.size(), 1);
    check("rd1_rsp_byte", rsp_b.size() > 0 ? rsp_b[0] : 8'hxx, 8'hC3);
    check("rd1_rsp_last", rsp_l.size() > 0 ? rsp_l[0] : 1'bx, 1);
    check("rd1_rsp_cycle", rsp_cyc.size() > 0 ? rsp_cyc[0] - t : -1, 12);
    check("rd1_done_cycle", dc0() - t, 12);
    check("rd1_err", de0(), 0);
    check("rd1_send_count", send_b.size(), 1);
    // RDB 0xA3, eight bytes 0x00..0x07
    issue(8'hA3, 8'h00, t);
    while (cyc < t + 8) tick();
    for (int i = 0; i < 8; i++) begin
      rx_byte(8'(i));
      tick();
      tick();
    end
    wait_done(40);
    check("rdb_rsp_count", rsp_b.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rdb_byte%0d", i), i < rsp_b.size() ? rsp_b[i] : 8'hxx, 8'(i));
      check($sformatf("rdb_last%0d", i), i < rsp_l.size() ? rsp_l[i] : 1'bx, i == 7);
    end
    check("rdb_done_count", done_cyc.size(), 1);
    check("rdb_done_with_last", dc0(), rsp_cyc.size() > 7 ? rsp_cyc[7] : -2);
    check("rdb_err", de0(), 0);
    // timeout: RD1 0x25 with no reply, done/err at T+6+20
    issue(8'h25, 8'h00, t);
    wait_done(60);
    check("tmo_done_cycle", dc0() - t, 26);
    check("tmo_err", de0(), 1);
    check("tmo_no_rsp", rsp_b.size(), 0);
    repeat (3) tick();
    check("tmo_err_held", err, 1);
    // next command (NONE 0x00) clears err on acceptance and completes at T+6
    issue(8'h00, 8'h00, t);
    check("err_cleared", err, 0);
    wait_done(40);
    check("none_done_cycle", dc0() - t, 6);
    check("none_err", de0(), 0);
    check("none_send_count", send_b.size(), 1);
    tick();
    // byte arriving on the timeout compare cycle (entry+19) wins
    issue(8'h53, 8'h00, t);
    while (cyc < t + 25) tick();
    rx_byte(8'h6E);
    wait_done(40);
    check("tie_rsp_count", rsp_b.size(), 1);
    check("tie_rsp_byte", rsp_b.size() > 0 ? rsp_b[0] : 8'hxx, 8'h6E);
    check("tie_done_cycle", dc0() - t, 26);
    check("tie_err", de0(), 0);
    tick();
    // busy: cmd_valid held through a WR1 issues exactly one command
    clr();
    cmd_valid = 1'b1;
    cmd_op    = 8'h44;
    cmd_data  = 8'h77;
    t         = cyc;
    for (int i = 0; i < 40 && done_cyc.size() == 0; i++) tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    check("busy_done_count", done_cyc.size(), 1);
    check("busy_send_count", send_b.size(), 2);
    check("busy_data_byte", send_b.size() > 1 ? send_b[1] : 8'hxx, 8'h77);
    check("busy_done_cycle", dc0() - t, 11);
    // stray receive edge during GAP_OP is discarded
    issue(8'h21, 8'h00, t);
    while (cyc < t + 3) tick();
    rx_byte(8'hEE);
    while (cyc < t + 8) tick();
    rx_byte(8'h99);
    wait_done(40);
    check("stray_rsp_count", rsp_b.size(), 1);
    check("stray_rsp_byte", rsp_b.size() > 0 ? rsp_b[0] : 8'hxx, 8'h99);
    check("stray_done_cycle", dc0() - t, 9);
    tick();
    // reset in the middle of an RDB after three bytes
    issue(8'hA3, 8'h00, t);
    while (cyc < t + 8) tick();
    for (int i = 0; i < 3; i++) begin
      rx_byte(8'hF0 + 8'(i));
      tick();
    end
    check("mid_rsp_count", rsp_b.size(), 3);
    sys_rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {cmd_ready, rsp_valid, rsp_data, rsp_last, done, err, uart_send, uart_data_w}, 0);
    repeat (2) tick();
    sys_rst_n = 1'b1;
    #1;
    check("mid_ready_after_release", cmd_ready, 1);
    repeat (30) tick();
    check("mid_no_done", done_cyc.size(), 0);
    issue(8'h10, 8'h00, t);
    wait_done(40);
    check("post_reset_done_cycle", dc0() - t, 6);
    check("post_reset_err", de0(), 0);
    check("post_reset_op_byte", send_b.size() > 0 ? send_b[0] : 8'hxx, 8'h10);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_mcu_host.md
# uart_mcu_host

FPGA-side command initiator for the UART debug/SDRAM bridge protocol. It accepts one command at a time from local logic and serializes the opcode, plus an optional data byte, into a byte-level UART transmitter. For read opcodes it collects the single response byte, or the 512-byte burst for 0xA3, from the UART receiver and reports completion or timeout. It sits between local control logic and a uart_hs-style byte transceiver that faces a remote bridge.

## Interface
Parameters:
- BYTE_GAP, 3000: idle cycles after each transmitted byte before the next byte or phase; covers one 10-bit frame plus margin.
- RSP_TIMEOUT, 1000000: maximum cycles to wait for each expected response byte.
- BURST_LEN, 512: byte count returned for opcode 0xA3.

Ports:
- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_op  in  8  opcode.
- cmd_data  in  8  data byte; used only by write-class opcodes.
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid & cmd_ready.
- rsp_valid  out  1  one-cycle pulse per received response byte.
- rsp_data  out  8  response byte; valid while rsp_valid is high, held afterwards.
- rsp_last  out  1  high with the final rsp_valid of a command.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  qualifies done: 1 = timeout; held until the next command is accepted.
- uart_send  out  1  one-cycle transmit strobe to the byte transmitter.
- uart_data_w  out  8  byte to transmit; valid with uart_send, held afterwards.
- uart_rec  in  1  receive-complete level from the byte receiver; its rising edge marks a new byte.
- uart_data_r  in  8  received byte; sampled on the cycle the rising edge is detected.

## Operation
- Opcode classes are decoded from the opcode latched at acceptance:
  - WR1: 0x30–0x37 and 0x40–0x47. Transmit opcode, then cmd_data. No response.
  - RD1: 0x20–0x27 and 0x50–0x57. Transmit opcode, then receive 1 byte.
  - RDB: 0xA3. Transmit opcode, then receive BURST_LEN bytes.
  - NONE: 0x00 and every other opcode. Transmit opcode only. No response.
- Opcode 0x00 is transmitted like any NONE opcode. The remote treats it as idle, so the bench uses it only as a protocol no-op.
- State machine:
  - IDLE → SEND_OP on acceptance. Latch op, data and class; clear err.
  - SEND_OP: uart_send=1, uart_data_w=op for 1 cycle → GAP_OP.
  - GAP_OP: count BYTE_GAP cycles, then:
    - WR1 → SEND_DATA.
    - RD1/RDB → WAIT_RSP.
    - NONE → FINISH.
  - SEND_DATA: 1-cycle strobe with the data byte → GAP_DATA.
  - GAP_DATA: count BYTE_GAP cycles → FINISH.
  - WAIT_RSP: a timeout counter restarts on entry and on every received byte.
    - On each received byte: rsp_valid=1 and rsp_data=byte on the next cycle; the byte counter increments.
    - Last expected byte (1 for RD1, BURST_LEN for RDB): rsp_last=1 and done=1 in the same cycle as that rsp_valid → IDLE.
    - Counter reaches RSP_TIMEOUT with bytes still outstanding: done=1, err=1 → IDLE. No further rsp_valid.
  - FINISH: done=1, err=0 for 1 cycle → IDLE.
- Receive-edge detector: uart_rec_last is a register that resets to 0; a received byte is uart_rec & ~uart_rec_last.
- Received bytes outside WAIT_RSP are discarded with no output effect.
- cmd_valid is ignored while not in IDLE; it is never queued.
- Width rules:
  - Gap and timeout counters are sized to hold their parameter and saturate at compare; no wrap.
  - The byte counter is 10 bits for BURST_LEN=512. BURST_LEN must be ≤ 1023.
- Reset, including mid-operation: state goes to IDLE. All outputs go to 0 (cmd_ready becomes 1 once out of reset). Counters clear. Any partial command is abandoned with no done pulse.

## Timing
- Command accepted at cycle T: uart_send high at T+1 carrying the opcode.
- WR1: second uart_send at T+2+BYTE_GAP; done at T+3+2·BYTE_GAP.
- NONE: done at T+2+BYTE_GAP.
- RD1/RDB: WAIT_RSP is entered at T+2+BYTE_GAP. A receive edge detected at cycle R gives rsp_valid at R+1.
- Timeout: done/err assert RSP_TIMEOUT cycles after the last counter restart.
- A receive edge and a timeout compare in the same cycle: the byte wins and the counter restarts.
- cmd_ready returns high the cycle after done; back-to-back commands are therefore separated by ≥1 idle cycle.

## Test plan
All scenarios use BYTE_GAP=4, RSP_TIMEOUT=20, BURST_LEN=8.
- WR1: op 0x31, data 0x5A → uart_send at T+1 (0x31) and T+6 (0x5A); done at T+11 with err=0; no rsp_valid.
- RD1: op 0x52, model replies 0xC3 five cycles after entering WAIT_RSP → exactly one rsp_valid with rsp_data=0xC3, rsp_last=1, done=1, err=0 together.
- RDB: op 0xA3, model returns 0x00..0x07 → eight rsp_valid pulses in order; rsp_last and done only on 0x07.
- Timeout: op 0x25 with no reply → done=1, err=1 exactly 20 cycles after WAIT_RSP entry; no rsp_valid. The next command's acceptance clears err.
- Busy and stray traffic: cmd_valid held during a WR1 → exactly one command issued. A uart_rec edge in GAP_OP → no rsp_valid.
- Reset mid-RDB after 3 bytes → all outputs 0 and no done pulse; cmd_ready=1 after release. A following 0x10 completes normally (done at T+6).
